fll_cfg_ctrl: RTL



---
 rtl/fll_cfg_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fll_cfg_ctrl.sv
// fll_cfg_ctrl: boot-time configuration sequencer for the FLL configuration port.
// On start it writes two configuration words (addresses 1 and 2), waits for a
// stable synchronized lock, then selects the FLL clock. Between boot sequences
// a software requester may issue single transactions on the same port.
module fll_cfg_ctrl #(
  parameter int unsigned ACK_TIMEOUT  = 64,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] cfg1_i,
  input  logic [31:0] cfg2_i,
  input  logic        sw_req_i,
  input  logic        sw_wrn_i,
  input  logic [1:0]  sw_add_i,
  input  logic [31:0] sw_wdata_i,
  output logic        sw_ack_o,
  output logic [31:0] sw_rdata_o,
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_r_data_i,
  input  logic        fll_lock_i,
  output logic        clk_sel_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR1       = 3'd1,
    WR2       = 3'd2,
    WAIT_LOCK = 3'd3,
    LOCKED    = 3'd4,
    ERR       = 3'd5,
    SW        = 3'd6
  } state_t;

  // Last allowed count values; a transaction or lock wait ends when reached.
  localparam logic [7:0]  ACK_LAST    = 8'(ACK_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  STABLE_GOAL = 8'(LOCK_STABLE);

  state_t      state;
  state_t      ret_state;   // resting state a software transaction returns to
  logic [1:0]  lock_sync_q;
  logic        lock_s;
  logic [7:0]  ack_cnt;     // cycles the current request has waited for ack
  logic [7:0]  stable_cnt;  // consecutive synchronized-lock-high cycles
  logic [15:0] wait_cnt;    // cycles spent in WAIT_LOCK
  logic        lock_lost;   // lock fell while serving software from LOCKED
  logic [31:0] cfg2_q;

  assign lock_s = lock_sync_q[1];
  assign busy_o = !(state inside {IDLE, LOCKED, ERR});

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], fll_lock_i};
    end
  end

  // Sequencer: boot writes, lock qualification, software arbitration and the
  // 4-phase FLL handshake, with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      ack_cnt    <= '0;
      stable_cnt <= '0;
      wait_cnt   <= '0;
      lock_lost  <= 1'b0;
      cfg2_q     <= '0;
      fll_req_o  <= 1'b0;
      fll_wrn_o  <= 1'b0;
      fll_add_o  <= '0;
      fll_data_o <= '0;
      sw_ack_o   <= 1'b0;
      sw_rdata_o <= '0;
      clk_sel_o  <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      // NOTE: every state register here uses <= so all branches see the
      // pre-edge values; a blocking write would leak into later conditions.
      sw_ack_o <= 1'b0;
      case (state)
        IDLE, LOCKED, ERR: begin
          if (start_i) begin
            cfg2_q     <= cfg2_i;
            fll_req_o  <= 1'b1;
            fll_wrn_o  <= 1'b0;
            fll_add_o  <= 2'd1;
            fll_data_o <= cfg1_i;
            ack_cnt    <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            clk_sel_o  <= 1'b0;
            state      <= WR1;
          end else if (state == LOCKED && !lock_s) begin
            state     <= ERR;
            err_o     <= 1'b1;
            clk_sel_o <= 1'b0;
            done_o    <= 1'b0;
          end else if (sw_req_i && !sw_ack_o) begin
            // sw_ack_o high means the requester has not yet seen completion
            fll_req_o  <= 1'b1;
            fll_wrn_o  <= sw_wrn_i;
            fll_add_o  <= sw_add_i;
            fll_data_o <= sw_wdata_i;
            ack_cnt    <= '0;
            lock_lost  <= 1'b0;
            ret_state  <= state;
            state      <= SW;
          end
        end

        WR1, WR2, SW: begin
          if (state == SW && ret_state == LOCKED && !lock_s) begin
            lock_lost <= 1'b1;
          end
          if (fll_req_o) begin
            if (fll_ack_i) begin
              fll_req_o <= 1'b0;
              if (state == SW) begin
                sw_ack_o   <= 1'b1;
                sw_rdata_o <= fll_wrn_o ? fll_r_data_i : '0;
              end
            end else if (ack_cnt == ACK_LAST) begin
              fll_req_o <= 1'b0;
              state     <= ERR;
              err_o     <= 1'b1;
              clk_sel_o <= 1'b0;
              done_o    <= 1'b0;
              if (state == SW) begin
                sw_ack_o   <= 1'b1;
                sw_rdata_o <= '0;
              end
            end else begin
              ack_cnt <= ack_cnt + 8'd1;
            end
          end else if (!fll_ack_i) begin
            // Release phase complete: ack has returned low
            case (state)
              WR1: begin
                fll_req_o  <= 1'b1;
                fll_wrn_o  <= 1'b0;
                fll_add_o  <= 2'd2;
                fll_data_o <= cfg2_q;
                ack_cnt    <= '0;
                state      <= WR2;
              end
              WR2: begin
                stable_cnt <= '0;
                wait_cnt   <= '0;
                state      <= WAIT_LOCK;
              end
              default: begin
                if (ret_state == LOCKED && (lock_lost || !lock_s)) begin
                  state     <= ERR;
                  err_o     <= 1'b1;
                  clk_sel_o <= 1'b0;
                  done_o    <= 1'b0;
                end else begin
                  state <= ret_state;
                end
              end
            endcase
          end
        end

        WAIT_LOCK: begin
          if (stable_cnt == STABLE_GOAL) begin
            state     <= LOCKED;
            clk_sel_o <= 1'b1;
            done_o    <= 1'b1;
          end else if (wait_cnt == LOCK_LAST) begin
            state <= ERR;
            err_o <= 1'b1;
          end else begin
            wait_cnt <= (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
            if (lock_s) begin
              stable_cnt <= (stable_cnt == 8'hFF) ? stable_cnt : stable_cnt + 8'd1;
            end else begin
              stable_cnt <= '0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          fll_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
